// File: rtl/btb_pkg.sv
// Shared defaults, entry layout and PC field helpers for the branch target buffer.
// Index is pc[IDX_W+1:2] and tag is pc[PC_W-1:IDX_W+2]. Bits [1:0] never take part.
package btb_pkg;

    localparam int BTB_ENTRIES  = 16;
    localparam int BTB_PC_W     = 32;
    localparam int BTB_CNT_W    = 32;
    localparam int BTB_IDX_W    = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W    = BTB_PC_W - BTB_IDX_W - 2;
    localparam int BTB_PC_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-1:0]  target;
    } btb_entry_t;

    // Helpers work on a zero-extended PC so any PC_W up to 64 can share them.
    // Callers truncate the result to their own index or tag width.
    function automatic logic [BTB_PC_MAX_W-1:0] btb_idx(input logic [BTB_PC_MAX_W-1:0] pc,
                                                        input int idx_w);
        return (pc >> 2) & ((BTB_PC_MAX_W'(1) << idx_w) - BTB_PC_MAX_W'(1));
    endfunction

    function automatic logic [BTB_PC_MAX_W-1:0] btb_tag(input logic [BTB_PC_MAX_W-1:0] pc,
                                                        input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// The count sticks at all-ones instead of wrapping.
module btb_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;

    // NOTE: state is written only with <= in always_ff. Reset has priority over increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency next-PC lookup in fetch, and
// mispredict detection, table update and statistics at branch resolution in EX.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int PC_W    = BTB_PC_W,
    parameter int CNT_W   = BTB_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PC_W-1:0]  i_if_pc,
    input  logic             i_prediction,
    output logic             o_btb_hit,
    output logic [PC_W-1:0]  o_pred_target,
    output logic [PC_W-1:0]  o_next_pc,
    output logic             o_pred_taken,
    input  logic             i_ex_valid,
    input  logic [PC_W-1:0]  i_ex_pc,
    input  logic             i_ex_taken,
    input  logic [PC_W-1:0]  i_ex_target,
    input  logic             i_ex_pred_taken,
    input  logic [PC_W-1:0]  i_ex_pred_target,
    input  logic             i_flush_all,
    output logic             o_mispredict,
    output logic [PC_W-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } entry_t;

    entry_t entries_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    entry_t           rd_entry;
    logic [PC_W-1:0]  if_seq_pc;
    logic [PC_W-1:0]  ex_expected_pc;
    logic             table_we;

    assign if_idx = IDX_W'(btb_idx(BTB_PC_MAX_W'(i_if_pc), IDX_W));
    assign if_tag = TAG_W'(btb_tag(BTB_PC_MAX_W'(i_if_pc), IDX_W));
    assign ex_idx = IDX_W'(btb_idx(BTB_PC_MAX_W'(i_ex_pc), IDX_W));
    assign ex_tag = TAG_W'(btb_tag(BTB_PC_MAX_W'(i_ex_pc), IDX_W));

    // Lookup reads the registered array directly, so a same-cycle update is seen next cycle.
    assign rd_entry      = entries_q[if_idx];
    assign if_seq_pc     = i_if_pc + PC_W'(4);
    assign o_btb_hit     = rd_entry.valid && (rd_entry.tag == if_tag);
    assign o_pred_target = o_btb_hit ? rd_entry.target : '0;
    assign o_pred_taken  = o_btb_hit & i_prediction;
    assign o_next_pc     = o_pred_taken ? rd_entry.target : if_seq_pc;

    // Wrong direction, or taken to a different target than the one fetched.
    assign ex_expected_pc = i_ex_taken ? i_ex_target : (i_ex_pc + PC_W'(4));
    assign o_mispredict   = i_ex_valid &
                            ((i_ex_taken != i_ex_pred_taken) |
                             (i_ex_taken & (i_ex_pred_target != i_ex_target)));
    assign o_redirect_pc  = i_ex_valid ? ex_expected_pc : '0;

    // Not-taken outcomes leave the entry alone; direction belongs to the predictor.
    assign table_we = i_ex_valid & i_ex_taken;

    // NOTE: only the valid bits are reset; tag and target are always qualified by valid,
    // so leaving them unreset lets the array map onto plain storage.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (table_we) begin
            entries_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: i_ex_target};
        end
    end

    btb_sat_counter #(.W(CNT_W)) u_branch_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (i_ex_valid),
        .o_cnt (o_branch_cnt)
    );

    btb_sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (o_mispredict),
        .o_cnt (o_mispred_cnt)
    );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized check of branch_target_buffer against an array-based model.
// Narrow counters let saturation be reached within a short run.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [PC_W-1:0]  i_if_pc;
    logic             i_prediction;
    logic             o_btb_hit;
    logic [PC_W-1:0]  o_pred_target;
    logic [PC_W-1:0]  o_next_pc;
    logic             o_pred_taken;
    logic             i_ex_valid;
    logic [PC_W-1:0]  i_ex_pc;
    logic             i_ex_taken;
    logic [PC_W-1:0]  i_ex_target;
    logic             i_ex_pred_taken;
    logic [PC_W-1:0]  i_ex_pred_target;
    logic             i_flush_all;
    logic             o_mispredict;
    logic [PC_W-1:0]  o_redirect_pc;
    logic [CNT_W-1:0] o_branch_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    branch_target_buffer #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_if_pc          (i_if_pc),
        .i_prediction     (i_prediction),
        .o_btb_hit        (o_btb_hit),
        .o_pred_target    (o_pred_target),
        .o_next_pc        (o_next_pc),
        .o_pred_taken     (o_pred_taken),
        .i_ex_valid       (i_ex_valid),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .i_flush_all      (i_flush_all),
        .o_mispredict     (o_mispredict),
        .o_redirect_pc    (o_redirect_pc),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispred_cnt    (o_mispred_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one slot per index holding the full upper PC as tag.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_branch;
    int          m_mispred;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ex(input bit v, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        i_ex_valid       = v;
        i_ex_pc          = pc;
        i_ex_taken       = tk;
        i_ex_target      = tgt;
        i_ex_pred_taken  = ptk;
        i_ex_pred_target = ptgt;
    endtask

    // Checks every output against the model, then clocks once and advances the model.
    task automatic run_cycle();
        int          idx;
        bit          hit;
        bit          misp;
        logic [31:0] nxt;
        logic [31:0] redir;
        #1;
        idx   = int'((i_if_pc / 4) % ENTRIES);
        hit   = m_valid[idx] && (m_tag[idx] == i_if_pc / (4 * ENTRIES));
        nxt   = (hit && i_prediction) ? m_target[idx] : i_if_pc + 32'd4;
        misp  = i_ex_valid && ((i_ex_taken != i_ex_pred_taken) ||
                               (i_ex_taken && i_ex_pred_target != i_ex_target));
        redir = !i_ex_valid ? 32'd0 : (i_ex_taken ? i_ex_target : i_ex_pc + 32'd4);
        check("hit",        64'(o_btb_hit),     64'(hit));
        check("pred_target",64'(o_pred_target), 64'(hit ? m_target[idx] : 32'd0));
        check("pred_taken", 64'(o_pred_taken),  64'(hit && i_prediction));
        check("next_pc",    64'(o_next_pc),     64'(nxt));
        check("mispredict", 64'(o_mispredict),  64'(misp));
        check("redirect",   64'(o_redirect_pc), 64'(redir));
        check("branch_cnt", 64'(o_branch_cnt),  64'(m_branch));
        check("mispred_cnt",64'(o_mispred_cnt), 64'(m_mispred));
        @(posedge i_clk);
        if (i_rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_branch  = 0;
            m_mispred = 0;
        end else begin
            if (i_ex_valid && m_branch < CNT_MAX) m_branch++;
            if (misp && m_mispred < CNT_MAX) m_mispred++;
            if (i_flush_all) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (i_ex_valid && i_ex_taken) begin
                idx           = int'((i_ex_pc / 4) % ENTRIES);
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = i_ex_pc / (4 * ENTRIES);
                m_target[idx] = i_ex_target;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 47) << 2) + 32'($urandom_range(0, 3) == 0 ? 2 : 0);
    endfunction

    initial begin
        logic [31:0] tgt;
        i_rst = 1'b1;
        i_if_pc = 32'h100;
        i_prediction = 1'b1;
        i_flush_all = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge i_clk);
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_branch  = 0;
        m_mispred = 0;
        #1;
        i_rst = 1'b0;

        // Post-reset lookup misses and falls through.
        #1;
        check("rst_hit",     64'(o_btb_hit),     64'd0);
        check("rst_next",    64'(o_next_pc),     64'h104);
        check("rst_bcnt",    64'(o_branch_cnt),  64'd0);
        check("rst_mcnt",    64'(o_mispred_cnt), 64'd0);
        run_cycle();

        // First taken resolve, with a same-cycle lookup of the same PC.
        set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        #1;
        check("alloc_misp",  64'(o_mispredict),  64'd1);
        check("alloc_redir", 64'(o_redirect_pc), 64'h200);
        check("same_cyc_hit",64'(o_btb_hit),     64'd0);
        run_cycle();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("hit_after",   64'(o_btb_hit),     64'd1);
        check("next_taken",  64'(o_next_pc),     64'h200);
        run_cycle();
        i_prediction = 1'b0;
        #1;
        check("next_ntaken", 64'(o_next_pc),     64'h104);
        run_cycle();

        // 0x140 shares the index of 0x100 with a different tag.
        set_ex(1'b1, 32'h140, 1'b1, 32'h280, 1'b1, 32'h280);
        #1;
        check("alias_nomisp",64'(o_mispredict),  64'd0);
        run_cycle();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        i_prediction = 1'b1;
        #1;
        check("alias_miss",  64'(o_btb_hit),     64'd0);
        run_cycle();
        i_if_pc = 32'h140;
        #1;
        check("alias_hit",   64'(o_btb_hit),     64'd1);
        check("alias_next",  64'(o_next_pc),     64'h280);
        run_cycle();

        // Target mismatch, then not-taken with a taken prediction.
        i_if_pc = 32'h100;
        set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        run_cycle();
        set_ex(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
        #1;
        check("tgt_misp",    64'(o_mispredict),  64'd1);
        check("tgt_redir",   64'(o_redirect_pc), 64'h300);
        run_cycle();
        set_ex(1'b1, 32'h100, 1'b0, 32'h300, 1'b1, 32'h300);
        #1;
        check("tgt_updated", 64'(o_next_pc),     64'h300);
        check("nt_misp",     64'(o_mispredict),  64'd1);
        check("nt_redir",    64'(o_redirect_pc), 64'h104);
        run_cycle();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("nt_retained", 64'(o_next_pc),     64'h300);
        run_cycle();

        // Sequential PC wraps at the top of the address space.
        i_if_pc = 32'hFFFF_FFFC;
        i_prediction = 1'b0;
        #1;
        check("wrap_next",   64'(o_next_pc),     64'h0);
        run_cycle();

        // Flush beats a same-cycle allocation.
        i_flush_all = 1'b1;
        set_ex(1'b1, 32'h180, 1'b1, 32'h400, 1'b1, 32'h400);
        run_cycle();
        i_flush_all = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        i_if_pc = 32'h180;
        i_prediction = 1'b1;
        #1;
        check("flush_miss_a",64'(o_btb_hit),     64'd0);
        run_cycle();
        i_if_pc = 32'h100;
        #1;
        check("flush_miss_b",64'(o_btb_hit),     64'd0);
        run_cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            i_if_pc      = rand_pc();
            i_prediction = 1'($urandom_range(0, 1));
            tgt          = rand_pc();
            set_ex(1'($urandom_range(0, 3) != 0), rand_pc(), 1'($urandom_range(0, 1)), tgt,
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? tgt : rand_pc());
            i_flush_all  = ($urandom_range(0, 59) == 0);
            i_rst        = ($urandom_range(0, 149) == 0);
            run_cycle();
        end
        i_rst = 1'b0;
        i_flush_all = 1'b0;

        // Continuous mispredicts drive both counters into saturation.
        for (int n = 0; n < 2 * CNT_MAX + 10; n++) begin
            i_if_pc = rand_pc();
            set_ex(1'b1, rand_pc(), 1'b1, 32'h500, 1'b0, 32'h0);
            run_cycle();
        end
        check("sat_bcnt",    64'(o_branch_cnt),  64'(CNT_MAX));
        check("sat_mcnt",    64'(o_mispred_cnt), 64'(CNT_MAX));

        // Mid-run reset drops the concurrent update and clears everything.
        i_rst = 1'b1;
        i_if_pc = 32'h100;
        set_ex(1'b1, 32'h100, 1'b1, 32'h600, 1'b0, 32'h0);
        run_cycle();
        i_rst = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("mrst_hit",    64'(o_btb_hit),     64'd0);
        check("mrst_bcnt",   64'(o_branch_cnt),  64'd0);
        check("mrst_mcnt",   64'(o_mispred_cnt), 64'd0);
        run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
